// File: rtl/riscv_fetch_req_ctrl_if.sv
// Bundle of the fetch controller's core, FIFO and instruction-memory signals.
//   core side : req_i, branch_i, branch_addr_i, busy_o
//   fifo side : fifo_ready_i, fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o
//   mem side  : instr_req_o, instr_addr_o, instr_gnt_i, instr_rvalid_i, instr_rdata_i
// master = the fetch controller, slave = its environment.
interface riscv_fetch_req_ctrl_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fifo_ready_i;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  modport master (
    input  req_i, branch_i, branch_addr_i, fifo_ready_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o,
    output instr_req_o, instr_addr_o, busy_o
  );

  modport slave (
    output req_i, branch_i, branch_addr_i, fifo_ready_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o,
    input  instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/riscv_fetch_req_ctrl.sv
// Instruction fetch request controller. Issues word-aligned memory requests
// with at most one granted-but-unanswered request, pushes responses into the
// fetch FIFO with zero latency, and handles branch redirects (including
// discarding the response of a request aborted by a branch).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : riscv_fetch_req_ctrl_if.master (core, FIFO and memory handshakes)
module riscv_fetch_req_ctrl (
  input  logic                          clk,
  input  logic                          rst_n,
  riscv_fetch_req_ctrl_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_ABORTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        booted_q, booted_d;

  logic        slot_ok;
  logic        can_issue;
  logic        instr_req;
  logic        accept;
  logic        push;
  logic [31:0] branch_tgt;
  logic [31:0] req_addr;
  logic [31:0] req_tag;

  // fetch_addr_q keeps bit1 of a branch target until that target is granted,
  // so the first request after a branch is tagged with the halfword address.
  // After any grant it holds a plain word address (bit1 = 0).
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    out_addr_d   = out_addr_q;
    booted_d     = booted_q | bus.branch_i;

    branch_tgt = bus.branch_addr_i & 32'hFFFF_FFFE;
    req_addr   = bus.branch_i ? {branch_tgt[31:2], 2'b00} : {fetch_addr_q[31:2], 2'b00};
    req_tag    = bus.branch_i ? branch_tgt : fetch_addr_q;

    unique case (state_q)
      IDLE:                      slot_ok = 1'b1;
      WAIT_RVALID, WAIT_ABORTED: slot_ok = bus.instr_rvalid_i;
      default:                   slot_ok = 1'b0;
    endcase

    // Nothing is fetched before the boot redirect has been seen.
    can_issue = bus.req_i & bus.fifo_ready_i & (booted_q | bus.branch_i) & slot_ok;
    instr_req = (state_q == WAIT_GNT) | can_issue;
    accept    = instr_req & bus.instr_gnt_i;
    push      = (state_q == WAIT_RVALID) & bus.instr_rvalid_i & ~bus.branch_i;

    unique case (state_q)
      IDLE: begin
        if (can_issue) state_d = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
      end
      WAIT_GNT: begin
        if (bus.instr_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID, WAIT_ABORTED: begin
        if (bus.instr_rvalid_i) begin
          if (can_issue) state_d = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
          else           state_d = IDLE;
        end else if (bus.branch_i) begin
          state_d = WAIT_ABORTED;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_addr_d   = req_tag;
      fetch_addr_d = req_addr + 32'd4;
    end else if (bus.branch_i) begin
      fetch_addr_d = branch_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      out_addr_q   <= '0;
      booted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      out_addr_q   <= out_addr_d;
      booted_q     <= booted_d;
    end
  end

  assign bus.fifo_clear_o = bus.branch_i;
  assign bus.fifo_valid_o = push;
  assign bus.fifo_addr_o  = out_addr_q;
  assign bus.fifo_rdata_o = bus.instr_rdata_i;
  assign bus.instr_req_o  = instr_req;
  assign bus.instr_addr_o = req_addr;
  assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_fetch_req_ctrl.sv
module tb_riscv_fetch_req_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_fetch_req_ctrl_if bus ();

  riscv_fetch_req_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Transaction-level reference: a queue of granted requests awaiting a
  // response (each tagged, possibly marked as discarded by a branch), a flag
  // for a request presented but not yet granted, and the next fetch address.
  typedef struct {
    logic [31:0] tag;
    bit          discard;
  } out_t;

  out_t        oq[$];
  bit          booted;
  bit          req_pend;
  logic [31:0] nxt;

  logic        e_issue, e_req, e_push, e_busy;
  logic [31:0] e_addr, e_faddr;

  task automatic model_reset();
    booted   = 0;
    req_pend = 0;
    nxt      = '0;
    oq.delete();
  endtask

  task automatic model_eval();
    bit slot_free;
    slot_free = !req_pend && (oq.size() == 0 || bus.instr_rvalid_i);
    e_issue   = bus.req_i && bus.fifo_ready_i && (booted || bus.branch_i) && slot_free;
    e_req     = req_pend || e_issue;
    e_addr    = bus.branch_i ? (bus.branch_addr_i & 32'hFFFF_FFFC) : (nxt & 32'hFFFF_FFFC);
    e_push    = oq.size() > 0 && bus.instr_rvalid_i && !oq[0].discard && !bus.branch_i;
    e_faddr   = (oq.size() > 0) ? oq[0].tag : '0;
    e_busy    = req_pend || oq.size() > 0;
  endtask

  task automatic model_update();
    if (oq.size() > 0 && bus.instr_rvalid_i) void'(oq.pop_front());
    else if (bus.branch_i && oq.size() > 0) oq[0].discard = 1;
    if (e_req && bus.instr_gnt_i) begin
      oq.push_back('{tag: (bus.branch_i ? bus.branch_addr_i : nxt), discard: 0});
      nxt      = e_addr + 32'd4;
      req_pend = 0;
    end else begin
      if (e_issue) req_pend = 1;
      if (bus.branch_i) nxt = bus.branch_addr_i;
    end
    if (bus.branch_i) booted = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rq, input logic br, input logic [31:0] ba,
                       input logic rdy, input logic gn, input logic rv);
    bus.req_i          = rq;
    bus.branch_i       = br;
    bus.branch_addr_i  = ba;
    bus.fifo_ready_i   = rdy;
    bus.instr_gnt_i    = gn;
    bus.instr_rvalid_i = rv;
    bus.instr_rdata_i  = $urandom;
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are compared
  // mid-cycle, then the model advances on the following rising edge.
  task automatic cycle();
    #2;
    model_eval();
    check("clear", {31'd0, bus.fifo_clear_o}, {31'd0, bus.branch_i});
    check("req",   {31'd0, bus.instr_req_o},  {31'd0, e_req});
    check("addr",  bus.instr_addr_o,          e_addr);
    check("valid", {31'd0, bus.fifo_valid_o}, {31'd0, e_push});
    check("busy",  {31'd0, bus.busy_o},       {31'd0, e_busy});
    if (e_push) begin
      check("faddr", bus.fifo_addr_o,  e_faddr);
      check("rdata", bus.fifo_rdata_o, bus.instr_rdata_i);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'd0, bus.instr_req_o},  32'd0);
    check("rst_valid", {31'd0, bus.fifo_valid_o}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy_o},       32'd0);
    rst_n = 1'b1;

    // No fetch before the boot redirect, whatever the other inputs do.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1, 1'(i), 1'(i >> 1));
      cycle();
    end

    // Boot redirect to 0x102 with same-cycle grant.
    drive(1'b1, 1'b1, 32'h0000_0102, 1'b1, 1'b1, 1'b0);
    #1;
    check("boot_addr",  bus.instr_addr_o, 32'h0000_0100);
    check("boot_clear", {31'd0, bus.fifo_clear_o}, 32'd1);
    cycle();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    #1;
    check("boot_push_addr", bus.fifo_addr_o,  32'h0000_0102);
    check("boot_next_addr", bus.instr_addr_o, 32'h0000_0104);
    cycle();

    // Streaming, then FIFO full stops new requests after the last push.
    repeat (4) begin
      drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      cycle();
    end
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    cycle();
    repeat (2) begin
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      cycle();
    end

    // Branch to 0x200 while a request to 0x108 awaits its response.
    drive(1'b1, 1'b1, 32'h0000_0108, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    #1;
    check("abort_novalid", {31'd0, bus.fifo_valid_o}, 32'd0);
    check("abort_reissue", bus.instr_addr_o, 32'h0000_0200);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle();

    // Grant withheld 5 cycles; branch to 0x302 in the third one.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();
    drive(1'b0, 1'b1, 32'h0000_0302, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("gnt_hold_req",  {31'd0, bus.instr_req_o}, 32'd1);
    check("gnt_hold_addr", bus.instr_addr_o, 32'h0000_0300);
    cycle();
    cycle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    #1;
    check("gnt_tag", bus.fifo_addr_o, 32'h0000_0302);
    cycle();

    // Address wrap.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    #1;
    check("wrap_addr", bus.instr_addr_o, 32'h0000_0000);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle();

    // Reset in the middle of an outstanding request; stale rvalid ignored.
    drive(1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst_req",   {31'd0, bus.instr_req_o},  32'd0);
    check("mrst_valid", {31'd0, bus.fifo_valid_o}, 32'd0);
    check("mrst_busy",  {31'd0, bus.busy_o},       32'd0);
    check("mrst_addr",  bus.instr_addr_o,          32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    #1;
    check("mrst_stale", {31'd0, bus.fifo_valid_o}, 32'd0);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            $urandom & 32'hFFFF_FFFE,
            $urandom_range(0, 4) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) < 3);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
